// File: rtl/totd_pulse_gen_40mhz.sv
// ---------------------------------------------------------------------------
// totd_pulse_gen_40mhz
//
// Synthetic FADC-like trace source for the 40 MHz compatibility ToTd path.
// The block builds a train of rectangular pulses. Each pulse is passed through
// a single-pole exponential tail, y <= sat(x + ((y*FD) >> FN)). This is the
// tail that the compatibility deconvolution later removes. The block runs in
// the CLK120 domain and only advances on ENABLE40 phase 0 (a "tick").
//
// Ports:
//   CLK120    120 MHz clock
//   RESET     synchronous, active-high reset
//   ENABLE40  40 MHz phase (0,1,2); logic advances only on phase 0
//   START     one-cycle request to begin a pulse train
//   BASELINE  pedestal added to every output sample
//   AMPL      rectangular pulse height above baseline
//   WIDTH     pulse length in 40 MHz samples (0 treated as 1)
//   SPACING   zero-input samples between pulses
//   NPULSES   pulses per train (0 treated as 1)
//   FD        tail numerator
//   FN        tail shift
//   ADC_OUT   generated sample, registered on each tick
//   BUSY      train in progress
//   DONE      one-CLK120 pulse at end of train
//
// Optional feature macro: COMPAT_PULSE_GEN_DITHER_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1)
//   steps on every tick. Its two LSBs are added to BASELINE+y before the
//   output saturation.
// ---------------------------------------------------------------------------
module totd_pulse_gen_40mhz #(
   parameter int ADC_WIDTH = 12,
   parameter int FD_BITS   = 8,
   parameter int FN_BITS   = 4,
   parameter int LEN_BITS  = 8
) (
   input  logic                 CLK120,
   input  logic                 RESET,
   input  logic [1:0]           ENABLE40,
   input  logic                 START,
   input  logic [ADC_WIDTH-1:0] BASELINE,
   input  logic [ADC_WIDTH-1:0] AMPL,
   input  logic [LEN_BITS-1:0]  WIDTH,
   input  logic [LEN_BITS-1:0]  SPACING,
   input  logic [LEN_BITS-1:0]  NPULSES,
   input  logic [FD_BITS-1:0]   FD,
   input  logic [FN_BITS-1:0]   FN,
   output logic [ADC_WIDTH-1:0] ADC_OUT,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int ACC_W   = ADC_WIDTH + 4;
   localparam int PROD_W  = ACC_W + FD_BITS;
   localparam int POW_RAW = (1 << FN_BITS) + 1;
   localparam int POW_W   = (POW_RAW > FD_BITS) ? POW_RAW : FD_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      GAP   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                 tick;
   logic                 pending;
   logic                 start_now;
   logic                 done_now;

   logic [ACC_W-1:0]     y;
   logic [ACC_W-1:0]     y_nxt;
   logic [ADC_WIDTH-1:0] x;

   logic [LEN_BITS-1:0]  width_cnt;
   logic [LEN_BITS-1:0]  width_cnt_nxt;
   logic [LEN_BITS-1:0]  gap_cnt;
   logic [LEN_BITS-1:0]  gap_cnt_nxt;
   logic [LEN_BITS-1:0]  pulse_cnt;
   logic [LEN_BITS-1:0]  pulse_cnt_nxt;

   logic [ADC_WIDTH-1:0] base_r;
   logic [ADC_WIDTH-1:0] ampl_r;
   logic [LEN_BITS-1:0]  width_r;
   logic [LEN_BITS-1:0]  spacing_r;
   logic [FD_BITS-1:0]   fd_r;
   logic [FN_BITS-1:0]   fn_r;

   logic [ADC_WIDTH-1:0] base_e;
   logic [ADC_WIDTH-1:0] ampl_e;
   logic [LEN_BITS-1:0]  width_e;
   logic [LEN_BITS-1:0]  spacing_e;
   logic [FD_BITS-1:0]   fd_e;
   logic [FN_BITS-1:0]   fn_e;
   logic [LEN_BITS-1:0]  width_m1;
   logic [LEN_BITS-1:0]  npulses_m1;

   logic [POW_W-1:0]     fn_pow;
   logic                 tail_en;
   logic [PROD_W-1:0]    prod;
   logic [PROD_W-1:0]    tail;
   logic [PROD_W:0]      acc_sum;
   logic [ACC_W:0]       adc_sum;
   logic [ADC_WIDTH-1:0] adc_nxt;
   logic [ACC_W:0]       dither;

`ifdef COMPAT_PULSE_GEN_DITHER_EN
   logic [15:0]          lfsr;
   logic                 lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign dither  = (ACC_W + 1)'(lfsr[1:0]);

   // The dither LFSR steps once per tick and is reseeded by RESET.
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         lfsr <= 16'hACE1;
      end else if (tick) begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end
`else
   assign dither = '0;
`endif

   assign tick = (ENABLE40 == 2'd0);

   // While IDLE, the live inputs act as the parameters. This makes the start
   // tick and idle output use current values. From then on, the captured
   // copies hold the train steady.
   assign base_e    = (state == IDLE) ? BASELINE : base_r;
   assign ampl_e    = (state == IDLE) ? AMPL     : ampl_r;
   assign width_e   = (state == IDLE) ? WIDTH    : width_r;
   assign spacing_e = (state == IDLE) ? SPACING  : spacing_r;
   assign fd_e      = (state == IDLE) ? FD       : fd_r;
   assign fn_e      = (state == IDLE) ? FN       : fn_r;

   // Counters hold "remaining after this sample", so a zero length is
   // promoted to one.
   assign width_m1   = (width_e == '0) ? '0 : width_e - LEN_BITS'(1);
   assign npulses_m1 = (NPULSES == '0) ? '0 : NPULSES - LEN_BITS'(1);

   // State register
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and pulse-input logic. Each tick's x is the sample of the
   // state being entered, so the tick that leaves IDLE already feeds AMPL.
   // The last HIGH/GAP tick chooses the following segment.
   always_comb begin
      state_nxt     = state;
      width_cnt_nxt = width_cnt;
      gap_cnt_nxt   = gap_cnt;
      pulse_cnt_nxt = pulse_cnt;
      x             = '0;
      start_now     = 1'b0;
      done_now      = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (pending) begin
                  state_nxt     = HIGH;
                  x             = ampl_e;
                  width_cnt_nxt = width_m1;
                  pulse_cnt_nxt = npulses_m1;
                  start_now     = 1'b1;
               end
            end
            HIGH: begin
               if (width_cnt != '0) begin
                  x             = ampl_e;
                  width_cnt_nxt = width_cnt - LEN_BITS'(1);
               end else if (pulse_cnt != '0) begin
                  pulse_cnt_nxt = pulse_cnt - LEN_BITS'(1);
                  if (spacing_e != '0) begin
                     state_nxt   = GAP;
                     gap_cnt_nxt = spacing_e - LEN_BITS'(1);
                  end else begin
                     x             = ampl_e;
                     width_cnt_nxt = width_m1;
                  end
               end else begin
                  state_nxt = DRAIN;
               end
            end
            GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt_nxt = gap_cnt - LEN_BITS'(1);
               end else begin
                  state_nxt     = HIGH;
                  x             = ampl_e;
                  width_cnt_nxt = width_m1;
               end
            end
            DRAIN: begin
               if (y == '0) begin
                  state_nxt = IDLE;
                  done_now  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Exponential tail accumulator with a full-width product. When FD >= 2^FN,
   // the tail term is dropped so that DRAIN always decays to zero. Both sums
   // saturate rather than wrap.
   always_comb begin
      fn_pow  = POW_W'(1) << fn_e;
      tail_en = (POW_W'(fd_e) < fn_pow);
      prod    = PROD_W'(y) * PROD_W'(fd_e);
      tail    = tail_en ? (prod >> fn_e) : '0;
      acc_sum = (PROD_W + 1)'(x) + (PROD_W + 1)'(tail);
      y_nxt   = (|acc_sum[PROD_W:ACC_W]) ? '1 : acc_sum[ACC_W-1:0];
      adc_sum = (ACC_W + 1)'(base_e) + (ACC_W + 1)'(y_nxt) + dither;
      adc_nxt = (|adc_sum[ACC_W:ADC_WIDTH]) ? '1 : adc_sum[ADC_WIDTH-1:0];
   end

   // Datapath and handshake registers. A START arriving on the DONE tick is
   // accepted, because BUSY is about to fall on that same edge.
   always_ff @(posedge CLK120) begin
      if (RESET) begin
         y         <= '0;
         ADC_OUT   <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         pending   <= 1'b0;
         width_cnt <= '0;
         gap_cnt   <= '0;
         pulse_cnt <= '0;
         base_r    <= '0;
         ampl_r    <= '0;
         width_r   <= '0;
         spacing_r <= '0;
         fd_r      <= '0;
         fn_r      <= '0;
      end else begin
         DONE <= done_now;
         if ((!BUSY || done_now) && START) begin
            pending <= 1'b1;
         end else if (start_now) begin
            pending <= 1'b0;
         end
         if (tick) begin
            y         <= y_nxt;
            ADC_OUT   <= adc_nxt;
            width_cnt <= width_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            pulse_cnt <= pulse_cnt_nxt;
            if (start_now) begin
               BUSY      <= 1'b1;
               base_r    <= BASELINE;
               ampl_r    <= AMPL;
               width_r   <= WIDTH;
               spacing_r <= SPACING;
               fd_r      <= FD;
               fn_r      <= FN;
            end else if (done_now) begin
               BUSY <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_totd_pulse_gen_40mhz.sv
// ---------------------------------------------------------------------------
// tb_totd_pulse_gen_40mhz
//
// Directed bench for totd_pulse_gen_40mhz. ENABLE40 free-runs 0,1,2 and is
// updated on the falling edge. Samples are read 1 ns after each tick edge.
// ---------------------------------------------------------------------------
module tb_totd_pulse_gen_40mhz;

   logic        CLK120;
   logic        RESET;
   logic [1:0]  ENABLE40;
   logic        START;
   logic [11:0] BASELINE;
   logic [11:0] AMPL;
   logic [7:0]  WIDTH;
   logic [7:0]  SPACING;
   logic [7:0]  NPULSES;
   logic [7:0]  FD;
   logic [3:0]  FN;
   logic [11:0] ADC_OUT;
   logic        BUSY;
   logic        DONE;

   int checks   = 0;
   int failures = 0;

   totd_pulse_gen_40mhz dut (
      .CLK120   (CLK120),
      .RESET    (RESET),
      .ENABLE40 (ENABLE40),
      .START    (START),
      .BASELINE (BASELINE),
      .AMPL     (AMPL),
      .WIDTH    (WIDTH),
      .SPACING  (SPACING),
      .NPULSES  (NPULSES),
      .FD       (FD),
      .FN       (FN),
      .ADC_OUT  (ADC_OUT),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   initial begin
      CLK120 = 1'b0;
      forever #5 CLK120 = ~CLK120;
   end

   initial begin
      ENABLE40 = 2'd0;
      forever begin
         @(negedge CLK120);
         ENABLE40 = (ENABLE40 == 2'd2) ? 2'd0 : ENABLE40 + 2'd1;
      end
   end

   // Advance to just after the next phase-0 rising edge
   task automatic next_tick;
      @(posedge CLK120);
      while (ENABLE40 != 2'd0) @(posedge CLK120);
      #1;
   endtask

   task automatic set_params(input int b, input int a, input int w, input int s,
                             input int n, input int fd, input int fn);
      BASELINE = 12'(b);
      AMPL     = 12'(a);
      WIDTH    = 8'(w);
      SPACING  = 8'(s);
      NPULSES  = 8'(n);
      FD       = 8'(fd);
      FN       = 4'(fn);
   endtask

   task automatic pulse_start;
      @(negedge CLK120);
      START = 1'b1;
      @(negedge CLK120);
      START = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge CLK120);
      RESET = 1'b1;
      repeat (4) @(negedge CLK120);
      RESET = 1'b0;
   endtask

   task automatic test_reset;
      set_params(50, 200, 3, 0, 1, 0, 4);
      @(negedge CLK120);
      RESET = 1'b1;
      repeat (3) @(posedge CLK120);
      #1;
      checks++;
      if (ADC_OUT !== 12'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_values adc=%0d busy=%0b done=%0b expected 0/0/0",
                  ADC_OUT, BUSY, DONE);
      end
      @(negedge CLK120);
      RESET = 1'b0;
      next_tick;
      checks++;
      if (ADC_OUT !== 12'd50) begin
         failures++;
         $display("[TB] FAIL idle_baseline adc=%0d expected 50", ADC_OUT);
      end
   endtask

   task automatic test_single_pulse;
      int exp_adc [5] = '{250, 250, 250, 50, 50};
      int exp_busy[5] = '{1, 1, 1, 1, 0};
      int exp_done[5] = '{0, 0, 0, 0, 1};
      set_params(50, 200, 3, 0, 1, 0, 4);
      pulse_start;
      checks++;
      if (BUSY !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_busy_pre busy=%0b expected 0", BUSY);
      end
      for (int i = 0; i < 5; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== 12'(exp_adc[i]) || BUSY !== 1'(exp_busy[i]) || DONE !== 1'(exp_done[i])) begin
            failures++;
            $display("[TB] FAIL single_tick%0d adc=%0d busy=%0b done=%0b expected %0d/%0b/%0b",
                     i, ADC_OUT, BUSY, DONE, exp_adc[i], exp_busy[i], exp_done[i]);
         end
      end
      @(posedge CLK120);
      #1;
      checks++;
      if (DONE !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_done_width done=%0b expected 0", DONE);
      end
   endtask

   task automatic test_tail;
      int exp_adc[10] = '{200, 100, 50, 25, 12, 6, 3, 1, 0, 0};
      set_params(0, 200, 1, 0, 1, 8, 4);
      pulse_start;
      for (int i = 0; i < 10; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== 12'(exp_adc[i]) || DONE !== (i == 9)) begin
            failures++;
            $display("[TB] FAIL tail_tick%0d adc=%0d done=%0b expected %0d/%0b",
                     i, ADC_OUT, DONE, exp_adc[i], (i == 9));
         end
      end
   endtask

   task automatic test_train;
      int exp_adc[12] = '{100, 100, 0, 0, 100, 100, 0, 0, 100, 100, 0, 0};
      set_params(0, 100, 2, 2, 3, 0, 4);
      pulse_start;
      for (int i = 0; i < 12; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== 12'(exp_adc[i]) || DONE !== (i == 11) || BUSY !== (i != 11)) begin
            failures++;
            $display("[TB] FAIL train_tick%0d adc=%0d done=%0b busy=%0b expected %0d/%0b/%0b",
                     i, ADC_OUT, DONE, BUSY, exp_adc[i], (i == 11), (i != 11));
         end
         if (i == 5) begin
            START = 1'b1;
            @(posedge CLK120);
            #1;
            START = 1'b0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== 12'd0 || BUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL train_ignored_start%0d adc=%0d busy=%0b expected 0/0",
                     i, ADC_OUT, BUSY);
         end
      end
   endtask

   task automatic test_saturation;
      bit seen_done;
      set_params(100, 4095, 3, 0, 1, 15, 4);
      pulse_start;
      for (int i = 0; i < 4; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== 12'd4095) begin
            failures++;
            $display("[TB] FAIL sat_tick%0d adc=%0d expected 4095", i, ADC_OUT);
         end
      end
      seen_done = 1'b0;
      for (int i = 0; i < 600 && !seen_done; i++) begin
         next_tick;
         if (DONE === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done || ADC_OUT !== 12'd100) begin
         failures++;
         $display("[TB] FAIL sat_drain done_seen=%0b adc=%0d expected 1/100", seen_done, ADC_OUT);
      end
      // FD = 2^FN disables the tail, so y drops to zero right after the pulse
      set_params(100, 4095, 2, 0, 1, 16, 4);
      pulse_start;
      for (int i = 0; i < 4; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== ((i < 2) ? 12'd4095 : 12'd100) || DONE !== (i == 3)) begin
            failures++;
            $display("[TB] FAIL notail_tick%0d adc=%0d done=%0b expected %0d/%0b",
                     i, ADC_OUT, DONE, (i < 2) ? 4095 : 100, (i == 3));
         end
      end
   endtask

   task automatic test_clamp;
      int bad;
      set_params(0, 4095, 255, 0, 1, 255, 8);
      pulse_start;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         next_tick;
         if (ADC_OUT !== 12'd4095) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("[TB] FAIL clamp_no_wrap bad_ticks=%0d expected 0 (last adc=%0d)", bad, ADC_OUT);
      end
      do_reset;
   endtask

   task automatic test_reset_mid;
      int done_hits;
      set_params(50, 200, 3, 0, 1, 0, 4);
      pulse_start;
      next_tick;
      next_tick;
      RESET = 1'b1;
      @(posedge CLK120);
      #1;
      checks++;
      if (ADC_OUT !== 12'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid adc=%0d busy=%0b done=%0b expected 0/0/0",
                  ADC_OUT, BUSY, DONE);
      end
      @(negedge CLK120);
      RESET = 1'b0;
      done_hits = 0;
      for (int i = 0; i < 36; i++) begin
         @(posedge CLK120);
         #1;
         if (DONE !== 1'b0) done_hits++;
      end
      checks++;
      if (done_hits != 0 || ADC_OUT !== 12'd50) begin
         failures++;
         $display("[TB] FAIL reset_mid_after done_hits=%0d adc=%0d expected 0/50", done_hits, ADC_OUT);
      end
      test_single_pulse;
   endtask

   task automatic test_back_to_back;
      int exp_adc[5] = '{250, 250, 250, 50, 50};
      set_params(50, 200, 3, 0, 1, 0, 4);
      pulse_start;
      for (int i = 0; i < 4; i++) next_tick;
      @(posedge CLK120);
      @(posedge CLK120);
      #1;
      START = 1'b1;
      next_tick;
      START = 1'b0;
      checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_done done=%0b busy=%0b expected 1/0", DONE, BUSY);
      end
      for (int i = 0; i < 5; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== 12'(exp_adc[i]) || DONE !== (i == 4)) begin
            failures++;
            $display("[TB] FAIL b2b_tick%0d adc=%0d done=%0b expected %0d/%0b",
                     i, ADC_OUT, DONE, exp_adc[i], (i == 4));
         end
      end
   endtask

`ifdef COMPAT_PULSE_GEN_DITHER_EN
   task automatic test_dither;
      logic [15:0] model;
      set_params(50, 200, 3, 0, 1, 0, 4);
      do_reset;
      model = 16'hACE1;
      for (int i = 0; i < 16; i++) begin
         next_tick;
         checks++;
         if (ADC_OUT !== 12'(50 + int'(model[1:0]))) begin
            failures++;
            $display("[TB] FAIL dither_tick%0d adc=%0d expected %0d", i, ADC_OUT, 50 + int'(model[1:0]));
         end
         model = {model[14:0], model[15] ^ model[13] ^ model[12] ^ model[10]};
      end
   endtask
`endif

   initial begin
      RESET = 1'b1;
      START = 1'b0;
      set_params(50, 200, 3, 0, 1, 0, 4);
`ifdef COMPAT_PULSE_GEN_DITHER_EN
      test_dither;
`else
      test_reset;
      test_single_pulse;
      test_tail;
      test_train;
      test_saturation;
      test_clamp;
      test_reset_mid;
      test_back_to_back;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
